// File: rtl/bus_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of one shared memory port.
// Round-robin between requesters, with a data-side bus lock and a per-access ack timeout.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        sync_rst_n,
    input  logic        clk_en,
    input  logic        inst_req,
    input  logic [29:0] inst_address,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [29:0] data_address,
    input  logic [3:0]  data_mask,
    input  logic [31:0] data_wdata,
    input  logic        bus_lock,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_address,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        grant_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    // Abort fires on the edge where the wait counter would reach TIMEOUT_CYCLES,
    // so mem_req stays high for exactly TIMEOUT_CYCLES cycles without an ack.
    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [9:0]  wait_reg, wait_next;
    logic        lock_reg, lock_next;
    logic        last_data_reg, last_data_next;
    logic        timeout_reg, timeout_next;
    logic        inst_ready_reg, inst_ready_next;
    logic        data_ready_reg, data_ready_next;
    logic [31:0] inst_rdata_reg, inst_rdata_next;
    logic [31:0] data_rdata_reg, data_rdata_next;
    logic [29:0] addr_reg, addr_next;
    logic        we_reg, we_next;
    logic [3:0]  mask_reg, mask_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        inst_win, data_win;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_reg      <= IDLE;
            wait_reg       <= '0;
            lock_reg       <= 1'b0;
            last_data_reg  <= 1'b1;
            timeout_reg    <= 1'b0;
            inst_ready_reg <= 1'b0;
            data_ready_reg <= 1'b0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            mask_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            wait_reg       <= wait_next;
            lock_reg       <= lock_next;
            last_data_reg  <= last_data_next;
            timeout_reg    <= timeout_next;
            inst_ready_reg <= inst_ready_next;
            data_ready_reg <= data_ready_next;
            inst_rdata_reg <= inst_rdata_next;
            data_rdata_reg <= data_rdata_next;
            addr_reg       <= addr_next;
            we_reg         <= we_next;
            mask_reg       <= mask_next;
            wdata_reg      <= wdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wait_next       = wait_reg;
        lock_next       = lock_reg;
        last_data_next  = last_data_reg;
        timeout_next    = timeout_reg;
        inst_ready_next = 1'b0;
        data_ready_next = 1'b0;
        inst_rdata_next = inst_rdata_reg;
        data_rdata_next = data_rdata_reg;
        addr_next       = addr_reg;
        we_next         = we_reg;
        mask_next       = mask_reg;
        wdata_next      = wdata_reg;
        // A held lock shuts the instruction side out entirely.
        inst_win = inst_req && !lock_reg && (!data_req || last_data_reg);
        data_win = data_req && (lock_reg || !inst_req || !last_data_reg);

        if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    if (inst_win) begin
                        state_next     = BUSY_I;
                        wait_next      = '0;
                        last_data_next = 1'b0;
                        addr_next      = inst_address;
                        we_next        = 1'b0;
                        mask_next      = 4'hF;
                        wdata_next     = '0;
                    end else if (data_win) begin
                        state_next     = BUSY_D;
                        wait_next      = '0;
                        last_data_next = 1'b1;
                        addr_next      = data_address;
                        we_next        = data_we;
                        mask_next      = data_mask;
                        wdata_next     = data_wdata;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack) begin
                        state_next = IDLE;
                        if (state_reg == BUSY_I) begin
                            inst_rdata_next = mem_rdata;
                            inst_ready_next = 1'b1;
                        end else begin
                            data_rdata_next = mem_rdata;
                            data_ready_next = 1'b1;
                            lock_next       = bus_lock;
                        end
                    end else if (wait_reg == WAIT_LAST) begin
                        // Aborted data access releases any lock so the bus cannot stay stuck.
                        state_next   = IDLE;
                        timeout_next = 1'b1;
                        if (state_reg == BUSY_I) begin
                            inst_rdata_next = '0;
                            inst_ready_next = 1'b1;
                        end else begin
                            data_rdata_next = '0;
                            data_ready_next = 1'b1;
                            lock_next       = 1'b0;
                        end
                    end else begin
                        wait_next = wait_reg + 10'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign mem_req     = (state_reg != IDLE);
    assign grant_data  = (state_reg == BUSY_D);
    assign mem_we      = we_reg;
    assign mem_address = addr_reg;
    assign mem_mask    = mask_reg;
    assign mem_wdata   = wdata_reg;
    assign inst_rdata  = inst_rdata_reg;
    assign inst_ready  = inst_ready_reg;
    assign data_rdata  = data_rdata_reg;
    assign data_ready  = data_ready_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: arbitration order, lock, timeout, reset and clock-enable freeze.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        sync_rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        inst_req = 1'b0;
    logic [29:0] inst_address = '0;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [29:0] data_address = '0;
    logic [3:0]  data_mask = 4'hF;
    logic [31:0] data_wdata = '0;
    logic        bus_lock = 1'b0;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_address;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        grant_data;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
        .inst_req(inst_req), .inst_address(inst_address),
        .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_req(data_req), .data_we(data_we), .data_address(data_address),
        .data_mask(data_mask), .data_wdata(data_wdata), .bus_lock(bus_lock),
        .data_rdata(data_rdata), .data_ready(data_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
        .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .grant_data(grant_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        step(); step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst_ready", 32'(inst_ready), 32'd0);
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        chk("rst_grant_data", 32'(grant_data), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_address), 32'd0);
        sync_rst_n = 1'b1;
        step();

        // Both active: inst first, then data, then inst again
        inst_req = 1'b1; inst_address = 30'h100;
        data_req = 1'b1; data_address = 30'h200; data_we = 1'b0; data_mask = 4'hF;
        step();
        chk("rr1_mem_req", 32'(mem_req), 32'd1);
        chk("rr1_grant_data", 32'(grant_data), 32'd0);
        chk("rr1_addr", 32'(mem_address), 32'h100);
        chk("rr1_mask", 32'(mem_mask), 32'hF);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        chk("rr1_inst_ready", 32'(inst_ready), 32'd1);
        chk("rr1_inst_rdata", inst_rdata, 32'h1111_1111);
        chk("rr1_idle_mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        step();
        chk("rr2_grant_data", 32'(grant_data), 32'd1);
        chk("rr2_addr", 32'(mem_address), 32'h200);
        chk("rr2_inst_ready_low", 32'(inst_ready), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        step();
        chk("rr2_data_ready", 32'(data_ready), 32'd1);
        chk("rr2_data_rdata", data_rdata, 32'h2222_2222);
        mem_ack = 1'b0;
        step();
        chk("rr3_grant_data", 32'(grant_data), 32'd0);
        chk("rr3_addr", 32'(mem_address), 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        step();
        chk("rr3_inst_rdata", inst_rdata, 32'h3333_3333);
        inst_req = 1'b0; data_req = 1'b0; mem_ack = 1'b0;
        step();

        // Data read of 0x10, inputs changed while pending
        data_req = 1'b1; data_we = 1'b0; data_address = 30'h10;
        step();
        chk("rd_grant_data", 32'(grant_data), 32'd1);
        chk("rd_we", 32'(mem_we), 32'd0);
        data_req = 1'b0; data_address = 30'h3FF;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        chk("rd_addr_stable", 32'(mem_address), 32'h10);
        step();
        chk("rd_data_ready", 32'(data_ready), 32'd1);
        chk("rd_data_rdata", data_rdata, 32'hDEAD_BEEF);
        chk("rd_inst_ready_low", 32'(inst_ready), 32'd0);
        mem_ack = 1'b0;
        step();
        chk("rd_ready_one_cycle", 32'(data_ready), 32'd0);
        chk("rd_rdata_held", data_rdata, 32'hDEAD_BEEF);

        // Locked write followed by unlocked read, inst waiting
        data_req = 1'b1; data_we = 1'b1; data_address = 30'h20;
        data_mask = 4'b0011; data_wdata = 32'hCAFE_F00D; bus_lock = 1'b1;
        step();
        chk("lk1_we", 32'(mem_we), 32'd1);
        chk("lk1_mask", 32'(mem_mask), 32'h3);
        chk("lk1_wdata", mem_wdata, 32'hCAFE_F00D);
        inst_req = 1'b1; inst_address = 30'h100;
        mem_ack = 1'b1; mem_rdata = 32'h0;
        step();
        chk("lk1_data_ready", 32'(data_ready), 32'd1);
        data_we = 1'b0; data_address = 30'h24; data_mask = 4'hF; bus_lock = 1'b0;
        mem_ack = 1'b0;
        step();
        chk("lk2_grant_data", 32'(grant_data), 32'd1);
        chk("lk2_addr", 32'(mem_address), 32'h24);
        mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
        step();
        chk("lk2_data_rdata", data_rdata, 32'h4444_4444);
        chk("lk2_inst_ready_low", 32'(inst_ready), 32'd0);
        data_req = 1'b0; mem_ack = 1'b0;
        step();
        chk("lk3_inst_granted", 32'(mem_req & ~grant_data), 32'd1);
        chk("lk3_addr", 32'(mem_address), 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        chk("lk3_inst_rdata", inst_rdata, 32'h5555_5555);
        inst_req = 1'b0; mem_ack = 1'b0;
        step();

        // Timeout with TIMEOUT_CYCLES=4
        inst_req = 1'b1; inst_address = 30'h40;
        step();
        inst_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_mem_req_%0d", i), 32'(mem_req), 32'd1);
            step();
        end
        chk("to_mem_req_drop", 32'(mem_req), 32'd0);
        chk("to_inst_ready", 32'(inst_ready), 32'd1);
        chk("to_inst_rdata", inst_rdata, 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        data_req = 1'b1; data_address = 30'h50;
        step();
        chk("to_next_granted", 32'(grant_data), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
        step();
        chk("to_next_rdata", data_rdata, 32'h6666_6666);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        data_req = 1'b0; mem_ack = 1'b0;
        step();

        // Reset during BUSY_D
        data_req = 1'b1; data_address = 30'h60;
        step();
        chk("rb_grant_data", 32'(grant_data), 32'd1);
        sync_rst_n = 1'b0; data_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        chk("rb_mem_req", 32'(mem_req), 32'd0);
        chk("rb_data_ready", 32'(data_ready), 32'd0);
        chk("rb_timeout", 32'(timeout_err), 32'd0);
        chk("rb_data_rdata", data_rdata, 32'd0);
        sync_rst_n = 1'b1; mem_ack = 1'b0;
        step();
        chk("rb_data_ready_after", 32'(data_ready), 32'd0);

        // Clock-enable freeze in BUSY_I
        inst_req = 1'b1; inst_address = 30'h70;
        step();
        chk("ce_busy", 32'(mem_req), 32'd1);
        inst_req = 1'b0; clk_en = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        chk("ce_ack_ignored", 32'(inst_ready), 32'd0);
        step();
        chk("ce_still_pending", 32'(mem_req), 32'd1);
        chk("ce_addr_held", 32'(mem_address), 32'h70);
        clk_en = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h8888_8888;
        step();
        chk("ce_inst_ready", 32'(inst_ready), 32'd1);
        chk("ce_inst_rdata", inst_rdata, 32'h8888_8888);
        chk("ce_no_timeout", 32'(timeout_err), 32'd0);
        mem_ack = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles a granted access waits for mem_ack before it is aborted; legal range 1..1023.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port sync_rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port clk_en, input, 1: global clock enable; low freezes all state.
REQ-005 SHALL have port inst_req, input, 1: instruction fetch request, read-only.
REQ-006 SHALL have port inst_address, input, 30: word address of the fetch.
REQ-007 SHALL have port inst_rdata, output, 32: fetched word, little-endian.
REQ-008 SHALL have port inst_ready, output, 1: one-cycle pulse marking inst_rdata valid.
REQ-009 SHALL have port data_req, input, 1: data access request.
REQ-010 SHALL have port data_we, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port data_address, input, 30: word address of the data access.
REQ-012 SHALL have port data_mask, input, 4: byte enables.
REQ-013 SHALL have port data_wdata, input, 32: write data, little-endian.
REQ-014 SHALL have port bus_lock, input, 1: data requester reserves the bus for its next access.
REQ-015 SHALL have port data_rdata, output, 32: read data.
REQ-016 SHALL have port data_ready, output, 1: one-cycle completion pulse for the data access.
REQ-017 SHALL have ports mem_req, mem_we (out, 1), mem_address (out, 30), mem_mask (out, 4), mem_wdata (out, 32): shared memory command.
REQ-018 SHALL have ports mem_rdata (in, 32) and mem_ack (in, 1): memory response; mem_ack high for one cycle completes the access.
REQ-019 SHALL have ports grant_data (out, 1), high while the data access owns the bus, and timeout_err (out, 1), a sticky abort flag.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY_I and BUSY_D.
REQ-021 In IDLE with clk_en=1, SHALL grant according to REQ-022 to REQ-024, register address, we, mask and wdata from the winner, and enter BUSY_I or BUSY_D on the next edge.
REQ-022 If only one requester is active, SHALL grant that requester.
REQ-023 If both requesters are active, SHALL grant the one not served last (round-robin); after reset, the data requester counts as served last, so the instruction requester wins first.
REQ-024 While lock_hold is set, SHALL grant only the data requester and ignore inst_req.
REQ-025 SHALL set lock_hold when a data access completes with bus_lock=1, and clear it when a data access completes with bus_lock=0.
REQ-026 In BUSY_x, SHALL drive mem_req=1 and the registered command; for an instruction access, mem_we=0 and mem_mask=4'hF.
REQ-027 SHALL hold command fields stable until mem_ack, regardless of changes on the requester inputs.
REQ-028 On mem_ack in BUSY_x, SHALL register mem_rdata into the matching rdata output, pulse the matching ready for exactly one cycle on the next cycle, and return to IDLE.
REQ-029 Minimum latency SHALL be: request in cycle 0, mem_req in cycle 1, mem_ack in cycle 1, ready in cycle 2; at least one IDLE cycle separates grants.
REQ-030 Outside BUSY_x, mem_req SHALL be 0; mem_ack received in IDLE SHALL be ignored.
REQ-031 Each ready output SHALL hold its rdata value until the next completion for that requester.
REQ-032 A 10-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ack.
REQ-033 When the wait counter reaches TIMEOUT_CYCLES, SHALL abort: drop mem_req, pulse the requester's ready with rdata=0, set timeout_err, and return to IDLE.
REQ-034 SHALL keep timeout_err set until reset.
REQ-035 If mem_ack arrives in the same cycle as the timeout condition, mem_ack SHALL win and no error is flagged.
REQ-036 With clk_en=0, FSM state, counter, lock_hold and the registered command SHALL hold, ready pulses SHALL not fire, and mem_ack SHALL be ignored.
REQ-037 grant_data SHALL equal (state==BUSY_D).

Reset
REQ-038 While sync_rst_n=0 at a clock edge, state SHALL become IDLE, and lock_hold, the wait counter, mem_req, inst_ready, data_ready, grant_data and timeout_err SHALL become 0.
REQ-039 On reset, inst_rdata, data_rdata and all mem_* command outputs SHALL become 0, and the round-robin pointer SHALL be set to "data served last".
REQ-040 Reset during BUSY_x SHALL abandon the access with no ready pulse; mem_req SHALL be low from the cycle after the reset edge.

Verification
REQ-041 Test: both requesters active after reset, mem_ack the cycle after mem_req -> the inst access goes first with inst_ready at cycle 2, then the data access; alternation continues while both stay active.
REQ-042 Test: data read to address 0x10 while mem returns 0xDEADBEEF -> data_rdata=0xDEADBEEF with a one-cycle data_ready pulse, and inst_ready stays 0.
REQ-043 Test: data write with bus_lock=1 (mask 4'b0011), then a second data access with bus_lock=0 while inst_req stays high -> both data accesses complete before any inst grant.
REQ-044 Test: TIMEOUT_CYCLES=4 and mem_ack never asserted -> mem_req drops after 4 wait cycles, inst_ready pulses with inst_rdata=0, timeout_err=1, and the next request is still served.
REQ-045 Test: sync_rst_n=0 asserted mid BUSY_D -> no data_ready pulse, mem_req=0 the next cycle, and timeout_err=0.
REQ-046 Test: clk_en=0 for 3 cycles while in BUSY_I, with mem_ack pulsed during the freeze -> the access stays pending and completes on the first mem_ack after clk_en returns to 1.
